// File: rtl/pic_pkg.sv
// Shared definitions for the PIC16C5x-style sequencer: ALU operation codes,
// 12-bit opcode masks/patterns, FSM state encoding and the default PC width.
package pic_pkg;

   localparam int PC_W_DEFAULT = 9;

   localparam logic [3:0] ALUOP_ADD        = 4'd0;
   localparam logic [3:0] ALUOP_SUB        = 4'd1;
   localparam logic [3:0] ALUOP_AND        = 4'd2;
   localparam logic [3:0] ALUOP_OR         = 4'd3;
   localparam logic [3:0] ALUOP_XOR        = 4'd4;
   localparam logic [3:0] ALUOP_COM        = 4'd5;
   localparam logic [3:0] ALUOP_ROR        = 4'd6;
   localparam logic [3:0] ALUOP_ROL        = 4'd7;
   localparam logic [3:0] ALUOP_SWAP       = 4'd8;
   localparam logic [3:0] ALUOP_PASSA      = 4'd9;
   localparam logic [3:0] ALUOP_PASSB      = 4'd10;
   localparam logic [3:0] ALUOP_BITCLR     = 4'd11;
   localparam logic [3:0] ALUOP_BITSET     = 4'd12;
   localparam logic [3:0] ALUOP_BITTESTCLR = 4'd13;
   localparam logic [3:0] ALUOP_BITTESTSET = 4'd14;

   // Masks select the opcode bits of each instruction class
   localparam logic [11:0] MASK_3 = 12'hE00;
   localparam logic [11:0] MASK_4 = 12'hF00;
   localparam logic [11:0] MASK_6 = 12'hFC0;
   localparam logic [11:0] MASK_7 = 12'hFE0;

   localparam logic [11:0] OP_MOVWF  = 12'h020;
   localparam logic [11:0] OP_CLRW   = 12'h040;
   localparam logic [11:0] OP_CLRF   = 12'h060;
   localparam logic [11:0] OP_SUBWF  = 12'h080;
   localparam logic [11:0] OP_DECF   = 12'h0C0;
   localparam logic [11:0] OP_IORWF  = 12'h100;
   localparam logic [11:0] OP_ANDWF  = 12'h140;
   localparam logic [11:0] OP_XORWF  = 12'h180;
   localparam logic [11:0] OP_ADDWF  = 12'h1C0;
   localparam logic [11:0] OP_MOVF   = 12'h200;
   localparam logic [11:0] OP_COMF   = 12'h240;
   localparam logic [11:0] OP_INCF   = 12'h280;
   localparam logic [11:0] OP_DECFSZ = 12'h2C0;
   localparam logic [11:0] OP_RRF    = 12'h300;
   localparam logic [11:0] OP_RLF    = 12'h340;
   localparam logic [11:0] OP_SWAPF  = 12'h380;
   localparam logic [11:0] OP_INCFSZ = 12'h3C0;
   localparam logic [11:0] OP_BCF    = 12'h400;
   localparam logic [11:0] OP_BSF    = 12'h500;
   localparam logic [11:0] OP_BTFSC  = 12'h600;
   localparam logic [11:0] OP_BTFSS  = 12'h700;
   localparam logic [11:0] OP_RETLW  = 12'h800;
   localparam logic [11:0] OP_CALL   = 12'h900;
   localparam logic [11:0] OP_GOTO   = 12'hA00;
   localparam logic [11:0] OP_MOVLW  = 12'hC00;
   localparam logic [11:0] OP_IORLW  = 12'hD00;
   localparam logic [11:0] OP_ANDLW  = 12'hE00;
   localparam logic [11:0] OP_XORLW  = 12'hF00;

   typedef enum logic {
      ST_FETCH = 1'b0,
      ST_EXEC  = 1'b1
   } state_t;

   function automatic logic is_op(input logic [11:0] ir, input logic [11:0] mask,
                                  input logic [11:0] pat);
      return (ir & mask) == pat;
   endfunction

endpackage

// File: rtl/pic_stack.sv
// Two-entry hardware return stack; overflow drops the oldest entry and
// underflow keeps returning the bottom entry.
module pic_stack #(
   parameter int PC_W = 9
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            push,
   input  logic            pop,
   input  logic [PC_W-1:0] push_data,
   output logic [PC_W-1:0] top
);

   logic [PC_W-1:0] s0_q, s0_d;
   logic [PC_W-1:0] s1_q, s1_d;

   always_comb begin
      s0_d = s0_q;
      s1_d = s1_q;
      if (push) begin
         s1_d = s0_q;
         s0_d = push_data;
      end else if (pop) begin
         s0_d = s1_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s0_q <= '0;
         s1_q <= '0;
      end else begin
         s0_q <= s0_d;
         s1_q <= s1_d;
      end
   end

   assign top = s0_q;

endmodule

// File: rtl/pic_ctrl.sv
// Two-cycle fetch/execute sequencer and decoder for a PIC16C5x-style core;
// owns PC, W, C/Z, the skip flag and the return stack.
module pic_ctrl import pic_pkg::*; #(
   parameter int              PC_W         = PC_W_DEFAULT,
   parameter logic [PC_W-1:0] RESET_VECTOR = PC_W'(9'h1FF)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            en,
   output logic [PC_W-1:0] prog_addr,
   output logic            prog_rd,
   input  logic [11:0]     prog_data,
   output logic [3:0]      alu_op,
   output logic [7:0]      alu_a,
   output logic [7:0]      alu_b,
   output logic            alu_cin,
   input  logic [7:0]      alu_res,
   input  logic            alu_cout,
   input  logic            alu_zero,
   output logic [4:0]      reg_addr,
   input  logic [7:0]      reg_rdata,
   output logic [7:0]      reg_wdata,
   output logic            reg_we,
   output logic [7:0]      w_out,
   output logic            status_c,
   output logic            status_z,
   output logic            retire
);

   state_t          state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d, pc_inc, stk_top;
   logic [7:0]      w_q, w_d;
   logic            c_q, c_d, z_q, z_d, skip_q, skip_d;
   logic            stk_push, stk_pop;
   logic            dst_f, dst_w, file_dst, upd_c, upd_z, skip_op;
   logic            op_goto, op_call, op_retlw;
   logic [11:0]     ir;

   assign ir     = prog_data;
   assign pc_inc = pc_q + PC_W'(1);

   pic_stack #(.PC_W(PC_W)) u_stack (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (stk_push),
      .pop       (stk_pop),
      .push_data (pc_inc),
      .top       (stk_top)
   );

   // Decode: ALU setup plus which results this instruction commits
   always_comb begin
      alu_op    = ALUOP_PASSA;
      alu_a     = reg_rdata;
      alu_b     = w_q;
      dst_f     = 1'b0;
      dst_w     = 1'b0;
      file_dst  = 1'b0;
      upd_c     = 1'b0;
      upd_z     = 1'b0;
      skip_op   = 1'b0;
      op_goto   = 1'b0;
      op_call   = 1'b0;
      op_retlw  = 1'b0;
      if (is_op(ir, MASK_7, OP_MOVWF)) begin
         alu_op = ALUOP_PASSB; dst_f = 1'b1;
      end else if (is_op(ir, MASK_7, OP_CLRW)) begin
         alu_op = ALUOP_PASSB; alu_b = 8'h00; dst_w = 1'b1; upd_z = 1'b1;
      end else if (is_op(ir, MASK_7, OP_CLRF)) begin
         alu_op = ALUOP_PASSB; alu_b = 8'h00; dst_f = 1'b1; upd_z = 1'b1;
      end else if (is_op(ir, MASK_6, OP_SUBWF)) begin
         alu_op = ALUOP_SUB; file_dst = 1'b1; upd_c = 1'b1; upd_z = 1'b1;
      end else if (is_op(ir, MASK_6, OP_DECF)) begin
         alu_op = ALUOP_SUB; alu_b = 8'h01; file_dst = 1'b1; upd_z = 1'b1;
      end else if (is_op(ir, MASK_6, OP_IORWF)) begin
         alu_op = ALUOP_OR; file_dst = 1'b1; upd_z = 1'b1;
      end else if (is_op(ir, MASK_6, OP_ANDWF)) begin
         alu_op = ALUOP_AND; file_dst = 1'b1; upd_z = 1'b1;
      end else if (is_op(ir, MASK_6, OP_XORWF)) begin
         alu_op = ALUOP_XOR; file_dst = 1'b1; upd_z = 1'b1;
      end else if (is_op(ir, MASK_6, OP_ADDWF)) begin
         alu_op = ALUOP_ADD; file_dst = 1'b1; upd_c = 1'b1; upd_z = 1'b1;
      end else if (is_op(ir, MASK_6, OP_MOVF)) begin
         alu_op = ALUOP_PASSA; file_dst = 1'b1; upd_z = 1'b1;
      end else if (is_op(ir, MASK_6, OP_COMF)) begin
         alu_op = ALUOP_COM; file_dst = 1'b1; upd_z = 1'b1;
      end else if (is_op(ir, MASK_6, OP_INCF)) begin
         alu_op = ALUOP_ADD; alu_b = 8'h01; file_dst = 1'b1; upd_z = 1'b1;
      end else if (is_op(ir, MASK_6, OP_DECFSZ)) begin
         alu_op = ALUOP_SUB; alu_b = 8'h01; file_dst = 1'b1; skip_op = 1'b1;
      end else if (is_op(ir, MASK_6, OP_RRF)) begin
         alu_op = ALUOP_ROR; file_dst = 1'b1; upd_c = 1'b1;
      end else if (is_op(ir, MASK_6, OP_RLF)) begin
         alu_op = ALUOP_ROL; file_dst = 1'b1; upd_c = 1'b1;
      end else if (is_op(ir, MASK_6, OP_SWAPF)) begin
         alu_op = ALUOP_SWAP; file_dst = 1'b1;
      end else if (is_op(ir, MASK_6, OP_INCFSZ)) begin
         alu_op = ALUOP_ADD; alu_b = 8'h01; file_dst = 1'b1; skip_op = 1'b1;
      end else if (is_op(ir, MASK_4, OP_BCF)) begin
         alu_op = ALUOP_BITCLR; alu_b = ir[7:0]; dst_f = 1'b1;
      end else if (is_op(ir, MASK_4, OP_BSF)) begin
         alu_op = ALUOP_BITSET; alu_b = ir[7:0]; dst_f = 1'b1;
      end else if (is_op(ir, MASK_4, OP_BTFSC)) begin
         alu_op = ALUOP_BITTESTCLR; alu_b = ir[7:0]; skip_op = 1'b1;
      end else if (is_op(ir, MASK_4, OP_BTFSS)) begin
         alu_op = ALUOP_BITTESTSET; alu_b = ir[7:0]; skip_op = 1'b1;
      end else if (is_op(ir, MASK_4, OP_RETLW)) begin
         op_retlw = 1'b1;
      end else if (is_op(ir, MASK_4, OP_CALL)) begin
         op_call = 1'b1;
      end else if (is_op(ir, MASK_3, OP_GOTO)) begin
         op_goto = 1'b1;
      end else if (is_op(ir, MASK_4, OP_MOVLW)) begin
         alu_op = ALUOP_PASSB; alu_a = w_q; alu_b = ir[7:0]; dst_w = 1'b1;
      end else if (is_op(ir, MASK_4, OP_IORLW)) begin
         alu_op = ALUOP_OR; alu_a = w_q; alu_b = ir[7:0]; dst_w = 1'b1; upd_z = 1'b1;
      end else if (is_op(ir, MASK_4, OP_ANDLW)) begin
         alu_op = ALUOP_AND; alu_a = w_q; alu_b = ir[7:0]; dst_w = 1'b1; upd_z = 1'b1;
      end else if (is_op(ir, MASK_4, OP_XORLW)) begin
         alu_op = ALUOP_XOR; alu_a = w_q; alu_b = ir[7:0]; dst_w = 1'b1; upd_z = 1'b1;
      end
      if (file_dst) begin
         dst_f = ir[5];
         dst_w = !ir[5];
      end
   end

   // Commit on the enabled EXEC edge; a pending skip turns this EXEC into a NOP
   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      w_d      = w_q;
      c_d      = c_q;
      z_d      = z_q;
      skip_d   = skip_q;
      stk_push = 1'b0;
      stk_pop  = 1'b0;
      if (en) begin
         if (state_q == ST_FETCH) begin
            state_d = ST_EXEC;
         end else begin
            state_d = ST_FETCH;
            pc_d    = pc_inc;
            skip_d  = 1'b0;
            if (!skip_q) begin
               if (dst_w)    w_d = alu_res;
               if (op_retlw) w_d = ir[7:0];
               if (upd_c)    c_d = alu_cout;
               if (upd_z)    z_d = alu_zero;
               skip_d = skip_op & alu_zero;
               if (op_goto) pc_d = PC_W'(ir[8:0]);
               if (op_call) begin
                  stk_push = 1'b1;
                  pc_d     = PC_W'(ir[7:0]);
               end
               if (op_retlw) begin
                  stk_pop = 1'b1;
                  pc_d    = stk_top;
               end
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_FETCH;
         pc_q    <= RESET_VECTOR;
         w_q     <= 8'h00;
         c_q     <= 1'b0;
         z_q     <= 1'b0;
         skip_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         w_q     <= w_d;
         c_q     <= c_d;
         z_q     <= z_d;
         skip_q  <= skip_d;
      end
   end

   assign prog_addr = pc_q;
   assign prog_rd   = (state_q == ST_FETCH);
   assign alu_cin   = c_q;
   assign reg_addr  = ir[4:0];
   assign reg_wdata = alu_res;
   assign reg_we    = (state_q == ST_EXEC) && en && !skip_q && dst_f;
   assign retire    = (state_q == ST_EXEC) && en;
   assign w_out     = w_q;
   assign status_c  = c_q;
   assign status_z  = z_q;

endmodule

// File: tb/tb_pic_ctrl.sv
// Bench for pic_ctrl: ROM, file bank and ALU models around the DUT, with an
// instruction-level reference model checked at every retirement.
module tb_pic_ctrl;
   import pic_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        en;
   logic [8:0]  prog_addr;
   logic        prog_rd;
   logic [11:0] prog_data;
   logic [3:0]  alu_op;
   logic [7:0]  alu_a, alu_b, alu_res;
   logic        alu_cin, alu_cout, alu_zero;
   logic [4:0]  reg_addr;
   logic [7:0]  reg_rdata, reg_wdata, w_out;
   logic        reg_we, status_c, status_z, retire;

   int nCompared = 0;
   int nMismatch = 0;

   logic [11:0] rom[512];
   logic [7:0]  regs[32];
   logic [7:0]  preload[32];

   // reference model state
   logic [8:0]  mpc;
   logic [7:0]  mw;
   logic        mc, mz, mskip;
   logic [7:0]  mregs[32];
   logic [8:0]  mstk[$];
   int          enCnt;
   bit          chkPend;
   int          we9Cnt;

   pic_ctrl #(.PC_W(9), .RESET_VECTOR(9'h1FF)) dut (
      .clk(clk), .rst_n(rst_n), .en(en),
      .prog_addr(prog_addr), .prog_rd(prog_rd), .prog_data(prog_data),
      .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin),
      .alu_res(alu_res), .alu_cout(alu_cout), .alu_zero(alu_zero),
      .reg_addr(reg_addr), .reg_rdata(reg_rdata), .reg_wdata(reg_wdata), .reg_we(reg_we),
      .w_out(w_out), .status_c(status_c), .status_z(status_z), .retire(retire)
   );

   always #5 clk = ~clk;

   // synchronous program ROM
   always @(posedge clk) begin
      if (prog_rd) prog_data <= rom[prog_addr];
   end

   // file register bank, reloaded from preload during reset
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 32; i++) regs[i] <= preload[i];
      end else if (reg_we) begin
         regs[reg_addr] <= reg_wdata;
      end
   end
   assign reg_rdata = regs[reg_addr];

   // behavioural ALU; bit tests report zero when the tested condition is true
   always_comb begin
      alu_res  = 8'h00;
      alu_cout = 1'b0;
      case (alu_op)
         ALUOP_ADD:        {alu_cout, alu_res} = 9'(alu_a) + 9'(alu_b);
         ALUOP_SUB:        begin alu_res = alu_a - alu_b; alu_cout = (alu_a >= alu_b); end
         ALUOP_AND:        alu_res = alu_a & alu_b;
         ALUOP_OR:         alu_res = alu_a | alu_b;
         ALUOP_XOR:        alu_res = alu_a ^ alu_b;
         ALUOP_COM:        alu_res = ~alu_a;
         ALUOP_ROR:        begin alu_res = {alu_cin, alu_a[7:1]}; alu_cout = alu_a[0]; end
         ALUOP_ROL:        begin alu_res = {alu_a[6:0], alu_cin}; alu_cout = alu_a[7]; end
         ALUOP_SWAP:       alu_res = {alu_a[3:0], alu_a[7:4]};
         ALUOP_PASSA:      alu_res = alu_a;
         ALUOP_PASSB:      alu_res = alu_b;
         ALUOP_BITCLR:     alu_res = alu_a & ~(8'h01 << alu_b[7:5]);
         ALUOP_BITSET:     alu_res = alu_a | (8'h01 << alu_b[7:5]);
         ALUOP_BITTESTCLR: alu_res = alu_a & (8'h01 << alu_b[7:5]);
         ALUOP_BITTESTSET: alu_res = ~alu_a & (8'h01 << alu_b[7:5]);
         default:          alu_res = 8'h00;
      endcase
   end
   assign alu_zero = (alu_res == 8'h00);

   task checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      nCompared++;
      if (actual !== expected) begin
         nMismatch++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, actual, expected, $time);
      end
   endtask

   // Executes one instruction at the ISA level and reports the expected file write
   task automatic modelStep(output logic expWe, output logic [4:0] expAddr,
                            output logic [7:0] expData);
      logic [11:0] ins;
      logic [7:0]  fv, k, r;
      logic [8:0]  npc;
      logic [2:0]  bsel;
      logic        toF, toW, fileDst, setZ, setC, newC, skip;
      ins = rom[mpc];
      fv = mregs[ins[4:0]];
      k = ins[7:0];
      bsel = ins[7:5];
      npc = mpc + 9'd1;
      r = 8'h00; toF = 0; toW = 0; fileDst = 0; setZ = 0; setC = 0; newC = mc; skip = 0;
      expWe = 0; expAddr = ins[4:0]; expData = 8'h00;
      if (mskip) begin
         mskip = 1'b0;
      end else begin
         casez (ins)
            12'b0000_001?_????: begin r = mw; toF = 1; end
            12'b0000_010?_????: begin r = 8'h00; toW = 1; setZ = 1; end
            12'b0000_011?_????: begin r = 8'h00; toF = 1; setZ = 1; end
            12'b0000_10??_????: begin r = fv - mw; newC = (fv >= mw); fileDst = 1; setC = 1; setZ = 1; end
            12'b0000_11??_????: begin r = fv - 8'd1; fileDst = 1; setZ = 1; end
            12'b0001_00??_????: begin r = fv | mw; fileDst = 1; setZ = 1; end
            12'b0001_01??_????: begin r = fv & mw; fileDst = 1; setZ = 1; end
            12'b0001_10??_????: begin r = fv ^ mw; fileDst = 1; setZ = 1; end
            12'b0001_11??_????: begin {newC, r} = 9'(fv) + 9'(mw); fileDst = 1; setC = 1; setZ = 1; end
            12'b0010_00??_????: begin r = fv; fileDst = 1; setZ = 1; end
            12'b0010_01??_????: begin r = ~fv; fileDst = 1; setZ = 1; end
            12'b0010_10??_????: begin r = fv + 8'd1; fileDst = 1; setZ = 1; end
            12'b0010_11??_????: begin r = fv - 8'd1; fileDst = 1; skip = (r == 8'h00); end
            12'b0011_00??_????: begin r = {mc, fv[7:1]}; newC = fv[0]; fileDst = 1; setC = 1; end
            12'b0011_01??_????: begin r = {fv[6:0], mc}; newC = fv[7]; fileDst = 1; setC = 1; end
            12'b0011_10??_????: begin r = {fv[3:0], fv[7:4]}; fileDst = 1; end
            12'b0011_11??_????: begin r = fv + 8'd1; fileDst = 1; skip = (r == 8'h00); end
            12'b0100_????_????: begin r = fv & ~(8'h01 << bsel); toF = 1; end
            12'b0101_????_????: begin r = fv | (8'h01 << bsel); toF = 1; end
            12'b0110_????_????: skip = !fv[bsel];
            12'b0111_????_????: skip = fv[bsel];
            12'b1000_????_????: begin mw = k; npc = mstk[0]; mstk[0] = mstk[1]; end
            12'b1001_????_????: begin mstk.push_front(npc); void'(mstk.pop_back()); npc = {1'b0, k}; end
            12'b101?_????_????: npc = ins[8:0];
            12'b1100_????_????: begin r = k; toW = 1; end
            12'b1101_????_????: begin r = mw | k; toW = 1; setZ = 1; end
            12'b1110_????_????: begin r = mw & k; toW = 1; setZ = 1; end
            12'b1111_????_????: begin r = mw ^ k; toW = 1; setZ = 1; end
            default: ;
         endcase
         if (fileDst) begin
            toF = ins[5];
            toW = !ins[5];
         end
         if (toF) begin
            mregs[ins[4:0]] = r;
            expWe = 1'b1;
            expData = r;
         end
         if (toW) mw = r;
         if (setZ) mz = (r == 8'h00);
         if (setC) mc = newC;
         mskip = skip;
      end
      mpc = npc;
   endtask

   // Retirement monitor: compares every commit against the reference model
   always @(negedge clk) begin
      logic       eWe;
      logic [4:0] eAddr;
      logic [7:0] eData;
      if (!rst_n) begin
         mpc = 9'h1FF; mw = 8'h00; mc = 1'b0; mz = 1'b0; mskip = 1'b0;
         mstk = '{9'h000, 9'h000};
         for (int i = 0; i < 32; i++) mregs[i] = preload[i];
         enCnt = 0;
         chkPend = 0;
      end else begin
         if (chkPend) begin
            checkOutput("pc_after", 32'(prog_addr), 32'(mpc));
            checkOutput("w_after", 32'(w_out), 32'(mw));
            checkOutput("c_after", 32'(status_c), 32'(mc));
            checkOutput("z_after", 32'(status_z), 32'(mz));
            chkPend = 0;
         end
         if (!en) begin
            checkOutput("gated_we_retire", 32'({reg_we, retire}), 32'd0);
         end else begin
            enCnt++;
            if (retire) begin
               checkOutput("cadence", 32'(enCnt), 32'd2);
               enCnt = 0;
               checkOutput("exec_pc", 32'(prog_addr), 32'(mpc));
               modelStep(eWe, eAddr, eData);
               checkOutput("reg_we", 32'(reg_we), 32'(eWe));
               if (eWe) begin
                  checkOutput("reg_addr", 32'(reg_addr), 32'(eAddr));
                  checkOutput("reg_wdata", 32'(reg_wdata), 32'(eData));
               end
               chkPend = 1;
            end else if (reg_we) begin
               checkOutput("stray_we", 32'(reg_we), 32'd0);
            end
         end
         if (reg_we && reg_addr == 5'd9) we9Cnt++;
      end
   end

   task applyStimulus(input int cycles, input int enPct);
      for (int n = 0; n < cycles; n++) begin
         @(posedge clk);
         #2 en = ($urandom_range(99) < enPct);
      end
   endtask

   task resetDut();
      en = 1'b1;
      rst_n = 1'b0;
      #1;
      checkOutput("rst_we", 32'(reg_we), 32'd0);
      checkOutput("rst_retire", 32'(retire), 32'd0);
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b1;
   endtask

   task waitFetch(input logic [8:0] addr);
      bit found = 0;
      for (int n = 0; n < 100 && !found; n++) begin
         @(negedge clk);
         if (prog_rd && prog_addr == addr) found = 1;
      end
      checkOutput("wait_fetch", 32'(found), 32'd1);
   endtask

   initial begin
      int diffs;
      rst_n = 1'b0;
      en = 1'b1;
      we9Cnt = 0;

      // Directed: ADDWF carry/zero, DECFSZ and BTFSS skips, en stall on MOVWF
      for (int i = 0; i < 512; i++) rom[i] = 12'h000;
      for (int i = 0; i < 32; i++) preload[i] = 8'h00;
      preload[16] = 8'hF1; preload[8] = 8'h01; preload[6] = 8'h08; preload[7] = 8'h00;
      rom[9'h000] = 12'hC0F; rom[9'h001] = 12'h1F0; rom[9'h002] = 12'h2E8;
      rom[9'h003] = 12'hC55; rom[9'h004] = 12'h766; rom[9'h005] = 12'hCAA;
      rom[9'h006] = 12'h767; rom[9'h007] = 12'h029; rom[9'h008] = 12'hA08;
      resetDut();
      @(negedge clk);
      checkOutput("reset_addr", 32'(prog_addr), 32'h1FF);
      checkOutput("reset_rd", 32'(prog_rd), 32'd1);
      checkOutput("reset_w", 32'(w_out), 32'd0);
      checkOutput("reset_cz", 32'({status_c, status_z}), 32'd0);
      @(negedge clk);
      @(negedge clk);
      checkOutput("wrap_addr", 32'(prog_addr), 32'h000);
      checkOutput("wrap_rd", 32'(prog_rd), 32'd1);
      we9Cnt = 0;
      waitFetch(9'h007);
      @(posedge clk);
      #2 en = 1'b0;
      repeat (5) @(posedge clk);
      #2 en = 1'b1;
      applyStimulus(20, 100);
      @(negedge clk);
      checkOutput("add_f10", 32'(regs[16]), 32'h00);
      checkOutput("decfsz_f8", 32'(regs[8]), 32'h00);
      checkOutput("movwf_f9", 32'(regs[9]), 32'h0F);
      checkOutput("f6_kept", 32'(regs[6]), 32'h08);
      checkOutput("w_final1", 32'(w_out), 32'h0F);
      checkOutput("c_final1", 32'(status_c), 32'd1);
      checkOutput("z_final1", 32'(status_z), 32'd1);
      checkOutput("movwf_we_pulses", 32'(we9Cnt), 32'd1);

      // Directed: three CALLs then three RETLWs, underflow duplicates
      for (int i = 0; i < 512; i++) rom[i] = 12'h000;
      rom[9'h000] = 12'h920; rom[9'h020] = 12'h940; rom[9'h040] = 12'h960;
      rom[9'h060] = 12'h801; rom[9'h041] = 12'h802; rom[9'h021] = 12'h803;
      resetDut();
      applyStimulus(30, 100);
      @(negedge clk);
      checkOutput("retlw_w", 32'(w_out), 32'h03);
      checkOutput("retlw_pc", 32'(prog_addr), 32'h021);

      // Reset asserted in the middle of an EXEC cycle
      waitFetch(9'h021);
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      checkOutput("abort_pc", 32'(prog_addr), 32'h1FF);
      checkOutput("abort_w", 32'(w_out), 32'h00);
      checkOutput("abort_we_retire", 32'({reg_we, retire}), 32'd0);
      checkOutput("abort_rd", 32'(prog_rd), 32'd1);

      // Random programs, register contents and enable pattern
      for (int p = 0; p < 3; p++) begin
         for (int i = 0; i < 512; i++) rom[i] = 12'($urandom);
         for (int i = 0; i < 32; i++) preload[i] = 8'($urandom);
         resetDut();
         applyStimulus(2000, 80);
         @(posedge clk);
         #2 en = 1'b0;
         repeat (2) @(posedge clk);
         @(negedge clk);
         diffs = 0;
         for (int i = 0; i < 32; i++) if (regs[i] !== mregs[i]) diffs++;
         checkOutput("regfile_diffs", 32'(diffs), 32'd0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
      $finish;
   end

endmodule
